// File: rtl/plane_drawer.sv
// Rendering stage: walks the ten planes and emits one VGA pixel write per cycle, erasing and/or
// drawing each visible sprite. Define PLANE_SHAPE_EN to gate pixels with a silhouette mask.
module plane_drawer #(
  parameter int unsigned SPRITE_W     = 4,
  parameter int unsigned SPRITE_H     = 4,
  parameter logic [2:0]  BG_COLOUR    = 3'b000,
  parameter logic [2:0]  PLANE_COLOUR = 3'b111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [79:0] x_bus,
  input  logic [79:0] y_bus,
  input  logic [9:0]  vis,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  localparam int unsigned DxW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int unsigned DyW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam logic [DxW-1:0] DxLast = DxW'(SPRITE_W - 1);
  localparam logic [DyW-1:0] DyLast = DyW'(SPRITE_H - 1);
  localparam logic [3:0] LastIdx = 4'd9;

  typedef enum logic [1:0] {StIdle, StScan, StDraw, StDone} state_t;

  state_t         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic           pass_q, pass_d;
  logic [DxW-1:0] dx_q, dx_d;
  logic [DyW-1:0] dy_q, dy_d;
  logic           draw_op_q;

  logic [7:0] nx_q [10];
  logic [7:0] ny_q [10];
  logic [7:0] px_q [10];
  logic [7:0] py_q [10];
  logic [9:0] nvis_q, pvis_q;

  logic       latch_new, commit_prev;
  state_t     adv_state;
  logic [3:0] adv_idx;
  logic       adv_pass;

  logic [7:0] base_x, base_y;
  logic [8:0] sum_x, sum_y;
  logic       in_bounds, shape_ok, plot_d;

  // Where the walk goes after finishing (or skipping) the current plane.
  always_comb begin
    adv_state = StDone;
    adv_idx   = idx_q;
    adv_pass  = pass_q;
    if (idx_q < LastIdx) begin
      adv_idx   = idx_q + 4'd1;
      adv_state = StScan;
    end else if (!pass_q && draw_op_q) begin
      adv_pass  = 1'b1;
      adv_idx   = 4'd0;
      adv_state = StScan;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pass_d      = pass_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    latch_new   = 1'b0;
    commit_prev = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          latch_new = 1'b1;
          idx_d     = 4'd0;
          pass_d    = ~op[0];
          state_d   = (op == 2'b00) ? StDone : StScan;
        end
      end
      StScan: begin
        if (pass_q ? nvis_q[idx_q] : pvis_q[idx_q]) begin
          dx_d    = '0;
          dy_d    = '0;
          state_d = StDraw;
        end else begin
          state_d = adv_state;
          idx_d   = adv_idx;
          pass_d  = adv_pass;
        end
      end
      StDraw: begin
        if (dx_q == DxLast) begin
          dx_d = '0;
          if (dy_q == DyLast) begin
            dy_d    = '0;
            state_d = adv_state;
            idx_d   = adv_idx;
            pass_d  = adv_pass;
          end else begin
            dy_d = dy_q + 1'b1;
          end
        end else begin
          dx_d = dx_q + 1'b1;
        end
      end
      StDone: begin
        commit_prev = draw_op_q;
        state_d     = StIdle;
      end
    endcase
  end

  // Outputs are registered from next-state values so the pixel appears in its own DRAW cycle.
  always_comb begin
    base_x    = pass_d ? nx_q[idx_d] : px_q[idx_d];
    base_y    = pass_d ? ny_q[idx_d] : py_q[idx_d];
    sum_x     = {1'b0, base_x} + 9'(dx_d);
    sum_y     = {1'b0, base_y} + 9'(dy_d);
    in_bounds = (sum_x <= 9'd159) && (sum_y <= 9'd119);
  end

`ifdef PLANE_SHAPE_EN
  // Silhouette, bit index {dy, dx}; rows 0..3 are 0110, 1111, 0110, 0110.
  localparam logic [15:0] ShapeMask = 16'b0110_0110_1111_0110;
  logic [3:0] shape_idx;
  always_comb begin
    shape_idx = {2'(dy_d), 2'(dx_d)};
    shape_ok  = ShapeMask[shape_idx];
  end
`else
  assign shape_ok = 1'b1;
`endif

  assign plot_d = (state_d == StDraw) && in_bounds && shape_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= 4'd0;
      pass_q    <= 1'b0;
      dx_q      <= '0;
      dy_q      <= '0;
      draw_op_q <= 1'b0;
      nvis_q    <= 10'd0;
      pvis_q    <= 10'd0;
      for (int i = 0; i < 10; i++) begin
        nx_q[i] <= 8'd0;
        ny_q[i] <= 8'd0;
        px_q[i] <= 8'd0;
        py_q[i] <= 8'd0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      if (latch_new) begin
        draw_op_q <= op[1];
        nvis_q    <= vis;
        for (int i = 0; i < 10; i++) begin
          nx_q[i] <= x_bus[8*i +: 8];
          ny_q[i] <= y_bus[8*i +: 8];
        end
      end
      if (commit_prev) begin
        pvis_q <= nvis_q;
        px_q   <= nx_q;
        py_q   <= ny_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vga_x  <= 8'd0;
      vga_y  <= 7'd0;
      colour <= 3'd0;
      plot   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      plot <= plot_d;
      busy <= (state_d != StIdle);
      done <= (state_d == StDone);
      if (state_d == StDraw) begin
        vga_x  <= sum_x[7:0];
        vga_y  <= sum_y[6:0];
        colour <= pass_d ? PLANE_COLOUR : BG_COLOUR;
      end
    end
  end

endmodule
